arb_req_agent: RTL and testbench

//  Requester side of the round-robin arbiter's req_vld/grant interface. Buffers commands per

---
 rtl/arb_req_agent.sv | 134 +++++++++++++
 tb/tb_arb_req_agent.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/arb_req_agent.sv
// Per-channel request FIFOs feeding one registered output slot on a one-hot grant (1 clk latency).
// Optional GNT_STAT_EN adds saturating per-channel pop counters on gnt_cnt.
module arb_req_agent #(
  parameter int CH    = 3,
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int IDW   = 2
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             en,
  input  logic [CH-1:0]    wr_vld,
  input  logic [CH*DW-1:0] wr_data,
  output logic [CH-1:0]    wr_rdy,
  output logic [CH-1:0]    req_vld,
  input  logic [CH-1:0]    grant,
  output logic             out_vld,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [IDW-1:0]   out_id,
`ifdef GNT_STAT_EN
  output logic [CH*16-1:0] gnt_cnt,
`endif
  output logic             err_multi
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DW-1:0]  mem_q [CH][DEPTH];
  logic [PW-1:0]  wp_q [CH];
  logic [PW-1:0]  wp_d [CH];
  logic [PW-1:0]  rp_q [CH];
  logic [PW-1:0]  rp_d [CH];
  logic [CH-1:0]  empty, full, push, pop_vec;
  logic           multi, onehot, slot_free, pop;
  logic [DW-1:0]  head;
  logic [IDW-1:0] pop_id;

  logic           out_vld_q, out_vld_d;
  logic [DW-1:0]  out_data_q, out_data_d;
  logic [IDW-1:0] out_id_q, out_id_d;
  logic           err_q, err_d;

  always_comb begin
    multi     = |(grant & (grant - CH'(1)));
    onehot    = (grant != '0) & ~multi;
    slot_free = ~out_vld_q | out_ready;
    head      = '0;
    pop_id    = '0;
    empty     = '0;
    full      = '0;
    push      = '0;
    for (int i = 0; i < CH; i++) begin
      empty[i] = (wp_q[i] == rp_q[i]);
      full[i]  = (wp_q[i][AW] != rp_q[i][AW]) && (wp_q[i][AW-1:0] == rp_q[i][AW-1:0]);
      push[i]  = wr_vld[i] & ~full[i];
      if (grant[i]) begin
        head   = mem_q[i][rp_q[i][AW-1:0]];
        pop_id = IDW'(i);
      end
    end
    // A pop needs exactly one granted channel that already held data last cycle.
    pop     = en & onehot & (|(grant & ~empty)) & slot_free;
    pop_vec = pop ? grant : '0;
    for (int i = 0; i < CH; i++) begin
      wp_d[i] = wp_q[i] + PW'(push[i]);
      rp_d[i] = rp_q[i] + PW'(pop_vec[i]);
    end

    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    if (pop) begin
      out_vld_d  = 1'b1;
      out_data_d = head;
      out_id_d   = pop_id;
    end else if (out_ready) begin
      out_vld_d  = 1'b0;
    end
    err_d = err_q | multi;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (push[i]) mem_q[i][wp_q[i][AW-1:0]] <= wr_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      for (int i = 0; i < CH; i++) begin
        wp_q[i] <= '0;
        rp_q[i] <= '0;
      end
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_id_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        wp_q[i] <= wp_d[i];
        rp_q[i] <= rp_d[i];
      end
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      err_q      <= err_d;
    end
  end

  assign wr_rdy    = ~full;
  assign req_vld   = {CH{en}} & ~empty;
  assign out_vld   = out_vld_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign err_multi = err_q;

`ifdef GNT_STAT_EN
  logic [15:0] cnt_q [CH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (!srst_n) cnt_q[i] <= '0;
      else if (pop_vec[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_cnt
    assign gnt_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_arb_req_agent.sv
// Directed bench for arb_req_agent with a queue-based reference model checked every cycle.
module tb_arb_req_agent;
  logic        clk = 1'b0;
  logic        srst_n, en, out_ready, out_vld, err_multi;
  logic [2:0]  wr_vld, wr_rdy, req_vld, grant;
  logic [23:0] wr_data;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
`ifdef GNT_STAT_EN
  logic [47:0] gnt_cnt;
`endif

  arb_req_agent #(.CH(3), .DW(8), .DEPTH(4), .IDW(2)) dut (
    .clk(clk), .srst_n(srst_n), .en(en), .wr_vld(wr_vld), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .req_vld(req_vld), .grant(grant), .out_vld(out_vld),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
`ifdef GNT_STAT_EN
    .gnt_cnt(gnt_cnt),
`endif
    .err_multi(err_multi)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: one queue per channel plus the output slot.
  logic [7:0] mq [3][$];
  bit         m_live = 0;
  bit         m_vld, m_err, m_free, m_pop;
  logic [7:0] m_data;
  int         m_id, m_n;
  int         m_sz [3];
  int         m_cnt [3];

  always @(posedge clk) begin
    if (!srst_n) begin
      for (int i = 0; i < 3; i++) begin
        mq[i].delete();
        m_cnt[i] = 0;
      end
      m_vld = 0; m_data = 0; m_id = 0; m_err = 0; m_live = 1;
    end else begin
      for (int i = 0; i < 3; i++) m_sz[i] = mq[i].size();
      m_free = !m_vld || out_ready;
      m_n    = $countones(grant);
      m_pop  = 0;
      if (m_n > 1) m_err = 1;
      for (int i = 0; i < 3; i++) begin
        if (en && m_n == 1 && grant[i] && m_sz[i] > 0 && m_free) begin
          m_pop  = 1;
          m_data = mq[i].pop_front();
          m_id   = i;
          if (m_cnt[i] < 65535) m_cnt[i]++;
        end
      end
      for (int i = 0; i < 3; i++)
        if (wr_vld[i] && m_sz[i] < 4) mq[i].push_back(wr_data[i*8 +: 8]);
      if (m_pop) m_vld = 1;
      else if (out_ready) m_vld = 0;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      logic [2:0] e_req, e_rdy;
      for (int i = 0; i < 3; i++) begin
        e_req[i] = en && (mq[i].size() > 0);
        e_rdy[i] = mq[i].size() < 4;
      end
      chk("mdl_out_vld", out_vld, m_vld);
      if (m_vld) begin
        chk("mdl_out_data", out_data, m_data);
        chk("mdl_out_id", out_id, m_id);
      end
      chk("mdl_req_vld", req_vld, e_req);
      chk("mdl_wr_rdy", wr_rdy, e_rdy);
      chk("mdl_err_multi", err_multi, m_err);
`ifdef GNT_STAT_EN
      for (int i = 0; i < 3; i++) chk("mdl_gnt_cnt", gnt_cnt[i*16 +: 16], m_cnt[i]);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_vld = 0; wr_data = 0; grant = 0; en = 1; out_ready = 1;
  endtask

  task automatic rst();
    idle();
    srst_n = 0;
    repeat (2) tick();
    srst_n = 1;
  endtask

  int         rr, nout, c;
  logic [2:0] g;
  logic [1:0] got_id [16];
  logic [7:0] got_dat [16];

  initial begin
    idle();
    srst_n = 0;
    // 1: reset state
    repeat (3) tick();
    chk("rst_out_vld", out_vld, 0);
    chk("rst_req_vld", req_vld, 3'b000);
    chk("rst_wr_rdy", wr_rdy, 3'b111);
    chk("rst_err", err_multi, 0);
    srst_n = 1;

    // 2: single word on ch1
    wr_vld = 3'b010; wr_data = 24'h00A500;
    tick();
    wr_vld = 0;
    chk("t2_req", req_vld, 3'b010);
    grant = 3'b010;
    tick();
    grant = 0;
    chk("t2_vld", out_vld, 1);
    chk("t2_data", out_data, 8'hA5);
    chk("t2_id", out_id, 1);
    chk("t2_req_after", req_vld, 3'b000);

    // 3: backpressure on ch0
    rst();
    wr_vld = 3'b001;
    wr_data = 24'h11; tick();
    wr_data = 24'h22; tick();
    wr_data = 24'h33; tick();
    wr_vld = 0; out_ready = 0; grant = 3'b001;
    tick();
    chk("t3_first", out_data, 8'h11);
    repeat (2) begin
      tick();
      chk("t3_hold_vld", out_vld, 1);
      chk("t3_hold_data", out_data, 8'h11);
    end
    out_ready = 1;
    tick(); chk("t3_second", out_data, 8'h22);
    tick(); chk("t3_third", out_data, 8'h33);
    tick(); chk("t3_drained", out_vld, 0);
    grant = 0;

    // 4: full FIFO, en=0 ignore, ordered drain
    rst();
    for (int k = 1; k <= 5; k++) begin
      wr_vld = 3'b100; wr_data = {8'(k), 16'h0};
      tick();
      if (k == 4) chk("t4_full", wr_rdy[2], 0);
    end
    wr_vld = 0; en = 0; grant = 3'b100;
    tick();
    chk("t4_en0_vld", out_vld, 0);
    chk("t4_en0_req", req_vld, 3'b000);
    en = 1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t4_drain_vld", out_vld, 1);
      chk("t4_drain_data", out_data, 8'(k));
    end
    tick(); chk("t4_only4", out_vld, 0);
    grant = 0;

    // 5: fairness with a round-robin grant driver
    rst();
    for (int k = 0; k < 4; k++) begin
      wr_vld = 3'b111; wr_data = {8'(8'h20 + k), 8'(8'h10 + k), 8'(k)};
      tick();
    end
    wr_vld = 0; rr = 0; nout = 0;
    repeat (16) begin
      g = 0;
      for (int j = 0; j < 3; j++) begin
        c = (rr + j) % 3;
        if (req_vld[c] && g == 0) begin
          g[c] = 1'b1;
          rr = (c + 1) % 3;
        end
      end
      grant = g;
      tick();
      if (out_vld && nout < 16) begin
        got_id[nout] = out_id; got_dat[nout] = out_data; nout++;
      end
    end
    grant = 0;
    chk("t5_count", nout, 12);
    for (int n = 0; n < 12; n++) begin
      chk("t5_id", got_id[n], n % 3);
      chk("t5_data", got_dat[n], 8'h10 * (n % 3) + n / 3);
    end
`ifdef GNT_STAT_EN
    chk("t5_gnt_cnt", gnt_cnt, {16'd4, 16'd4, 16'd4});
`endif

    // 6: multi-hot grant
    rst();
    wr_vld = 3'b011; wr_data = 24'h00BBAA;
    tick();
    wr_vld = 0; grant = 3'b011;
    tick();
    grant = 0;
    chk("t6_nopop", out_vld, 0);
    chk("t6_err", err_multi, 1);
    chk("t6_req", req_vld, 3'b011);
    repeat (3) tick();
    chk("t6_sticky", err_multi, 1);
    srst_n = 0;
    tick();
    chk("t6_cleared", err_multi, 0);
    srst_n = 1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
